// File: rtl/pulse_to_level.sv
// Stretches single-cycle strobes into registered high windows, each followed by a low gap.
// Optional sticky drop flag (ovf/ovf_clr) when PULSE_STRETCH_OVF_EN is defined.
module pulse_to_level #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  hold_cycles,
    input  logic [CNT_W-1:0]  gap_cycles,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending
`ifdef PULSE_STRETCH_OVF_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);

    typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

    localparam logic [PEND_W-1:0] PendMax = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              level_q, level_d;
    logic              req, cnt_zero, dispatch, pend_full;
    logic [CNT_W-1:0]  hold_load, gap_load;

    assign req       = pulse_in || (pend_q != '0);
    assign cnt_zero  = (cnt_q == '0);
    // A length of zero behaves as one cycle.
    assign hold_load = (hold_cycles == '0) ? '0 : hold_cycles - CNT_W'(1);
    assign gap_load  = (gap_cycles == '0) ? '0 : gap_cycles - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dispatch = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d  = StHigh;
                    cnt_d    = hold_load;
                    dispatch = 1'b1;
                end
            end
            StHigh: begin
                if (cnt_zero) begin
                    state_d = StGap;
                    cnt_d   = gap_load;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (req) begin
                    state_d  = StHigh;
                    cnt_d    = hold_load;
                    dispatch = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = (state_d == StHigh);
        pend_full = (pend_q == PendMax);
        pend_d    = pend_q;
        // A strobe coinciding with a dispatch is consumed directly and never queued.
        if (pulse_in && !dispatch && !pend_full) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (!pulse_in && dispatch && (pend_q != '0)) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    assign level_out = level_q;
    assign pending   = pend_q;
    assign busy      = (state_q != StIdle) || (pend_q != '0);

`ifdef PULSE_STRETCH_OVF_EN
    logic drop;
    logic ovf_q, ovf_d;

    assign drop  = pulse_in && !dispatch && pend_full;
    // A drop in the same cycle as a clear keeps the flag set.
    assign ovf_d = drop || (ovf_q && !ovf_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pulse_to_level.sv
// Scoreboarded bench for pulse_to_level: stimulus queues expected windows, a monitor measures them.
// Uses PEND_W=2 so saturation is reachable with few pulses.
module tb_pulse_to_level;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PEND_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pulse_in = 1'b0;
    logic [CNT_W-1:0]  hold_cycles = '0;
    logic [CNT_W-1:0]  gap_cycles = '0;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
`ifdef PULSE_STRETCH_OVF_EN
    logic              ovf;
    logic              ovf_clr = 1'b0;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int start;
        int len;
    } win_t;
    win_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_to_level #(
        .CNT_W (CNT_W),
        .PEND_W(PEND_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .hold_cycles(hold_cycles),
        .gap_cycles (gap_cycles),
        .level_out  (level_out),
        .busy       (busy),
        .pending    (pending)
`ifdef PULSE_STRETCH_OVF_EN
        ,
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_win(input int s, input int l);
        win_t w;
        w.start = s;
        w.len   = l;
        exp_q.push_back(w);
    endtask

    // Monitor: every completed high window is compared against the next expected one.
    logic mon_prev = 1'b0;
    int   mon_start = 0;
    initial begin : monitor
        win_t w;
        forever begin
            @(negedge clk);
            if (level_out === 1'b1 && !mon_prev) begin
                mon_start = cyc;
            end else if (level_out !== 1'b1 && mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_window: got start %0d len %0d, want none",
                             mon_start, cyc - mon_start);
                end else begin
                    w = exp_q.pop_front();
                    check("win_start", mon_start, w.start);
                    check("win_len", cyc - mon_start, w.len);
                end
            end
            mon_prev = (level_out === 1'b1);
        end
    end

    initial begin : stimulus
        int b;

        // Reset held for two edges.
        rst = 1'b1;
        tick();
        tick();
        sample();
        check("rst_level", int'(level_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pending", int'(pending), 0);
`ifdef PULSE_STRETCH_OVF_EN
        check("rst_ovf", int'(ovf), 0);
`endif
        tick();
        rst = 1'b0;

        // Single pulse, hold=3 gap=2; a mid-window hold change must not matter.
        hold_cycles = 8'd3;
        gap_cycles  = 8'd2;
        b = cyc + 2;
        goto(b);
        pulse_in = 1'b1;
        expect_win(b + 1, 3);
        goto(b + 1);
        pulse_in = 1'b0;
        goto(b + 2);
        hold_cycles = 8'd7;
        goto(b + 3);
        sample();
        check("t2_level_hi", int'(level_out), 1);
        goto(b + 4);
        sample();
        check("t2_level_lo", int'(level_out), 0);
        goto(b + 5);
        sample();
        check("t2_busy_gap", int'(busy), 1);
        goto(b + 6);
        sample();
        check("t2_busy_idle", int'(busy), 0);

        // Queued requests, hold=2 gap=1.
        hold_cycles = 8'd2;
        gap_cycles  = 8'd1;
        b = cyc + 2;
        goto(b);
        pulse_in = 1'b1;
        expect_win(b + 1, 2);
        expect_win(b + 4, 2);
        expect_win(b + 7, 2);
        goto(b + 3);
        pulse_in = 1'b0;
        sample();
        check("t3_pending2", int'(pending), 2);
        goto(b + 7);
        sample();
        check("t3_pending0", int'(pending), 0);
        goto(b + 12);
        sample();
        check("t3_busy_idle", int'(busy), 0);

        // Zero lengths behave as one.
        hold_cycles = 8'd0;
        gap_cycles  = 8'd0;
        b = cyc + 2;
        goto(b);
        pulse_in = 1'b1;
        expect_win(b + 1, 1);
        expect_win(b + 3, 1);
        goto(b + 2);
        pulse_in = 1'b0;
        sample();
        check("t4_gap_low", int'(level_out), 0);
        goto(b + 3);
        sample();
        check("t4_second_hi", int'(level_out), 1);
        goto(b + 4);
        sample();
        check("t4_after_low", int'(level_out), 0);
        goto(b + 8);

        // Saturation: six pulses, pending caps at 3, two dropped, four windows.
        hold_cycles = 8'd10;
        gap_cycles  = 8'd1;
        b = cyc + 2;
        goto(b);
        pulse_in = 1'b1;
        expect_win(b + 1, 10);
        expect_win(b + 12, 10);
        expect_win(b + 23, 10);
        expect_win(b + 34, 10);
        goto(b + 5);
`ifdef PULSE_STRETCH_OVF_EN
        ovf_clr = 1'b1;
`endif
        goto(b + 6);
        pulse_in = 1'b0;
        sample();
        check("t5_pending_sat", int'(pending), 3);
`ifdef PULSE_STRETCH_OVF_EN
        check("t5_ovf_drop_wins", int'(ovf), 1);
        goto(b + 7);
        ovf_clr = 1'b0;
        sample();
        check("t5_ovf_cleared", int'(ovf), 0);
`endif
        goto(b + 12);
        sample();
        check("t5_pending_after_dispatch", int'(pending), 2);
        goto(b + 50);
        sample();
        check("t5_busy_idle", int'(busy), 0);

        // Reset in the fourth HIGH cycle with two requests queued.
        hold_cycles = 8'd8;
        gap_cycles  = 8'd1;
        b = cyc + 2;
        goto(b);
        pulse_in = 1'b1;
        expect_win(b + 1, 4);
        goto(b + 3);
        pulse_in = 1'b0;
        sample();
        check("t6_pending_pre", int'(pending), 2);
        goto(b + 4);
        rst = 1'b1;
        goto(b + 5);
        rst = 1'b0;
        sample();
        check("t6_level", int'(level_out), 0);
        check("t6_pending", int'(pending), 0);
        check("t6_busy", int'(busy), 0);
        goto(b + 35);
        sample();
        check("t6_level_quiet", int'(level_out), 0);
        check("windows_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
